// File: rtl/div_pkg.sv
// Shared constants and state encoding for the multi-cycle divider.
package div_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic [31:0] ZeroWord          = 32'h0000_0000;
  localparam logic        RstActive         = 1'b0;
  localparam logic        DivResultReady    = 1'b1;
  localparam logic        DivResultNotReady = 1'b0;
  localparam logic        DivStart          = 1'b1;
  localparam logic        DivStop           = 1'b0;

  // Two's-complement magnitude when the operand is treated as signed and negative.
  function automatic logic [31:0] abs_mag(input logic is_signed, input logic [31:0] v);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div.sv
// Restoring shift-subtract 32-bit divider, one quotient bit per clock; result = {rem, quot}.
// Optional early-out for |op1| < |op2| when DIV_EARLY_OUT_EN is defined.
module div
  import div_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            signed_div_i,
  input  logic [DW-1:0]   opdata1_i,
  input  logic [DW-1:0]   opdata2_i,
  input  logic            start_i,
  input  logic            annul_i,
  output logic [2*DW-1:0] result_o,
  output logic            ready_o
);

`ifdef DIV_EARLY_OUT_EN
  localparam bit EarlyOutEn = 1'b1;
`else
  localparam bit EarlyOutEn = 1'b0;
`endif

  localparam logic [5:0] CntDone = 6'(DW);

  div_state_e      state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [2*DW:0]   work_q, work_d;
  logic [DW-1:0]   divisor_q, divisor_d;
  logic            neg_quot_q, neg_quot_d;
  logic            neg_rem_q, neg_rem_d;
  logic [2*DW-1:0] result_q, result_d;
  logic            ready_q, ready_d;

  logic [DW-1:0]   abs1, abs2;
  logic [DW:0]     diff;
  logic [DW-1:0]   quot, rem;
  logic            op_go, div_zero, early_out;

  assign abs1      = abs_mag(signed_div_i, opdata1_i);
  assign abs2      = abs_mag(signed_div_i, opdata2_i);
  assign op_go     = (start_i == DivStart) && !annul_i;
  assign div_zero  = (opdata2_i == ZeroWord);
  assign early_out = EarlyOutEn && (abs1 < abs2);

  // 33-bit trial subtraction; bit DW set means the partial remainder was too small.
  assign diff = {1'b0, work_q[2*DW-1:DW]} - {1'b0, divisor_q};
  assign quot = neg_quot_q ? (~work_q[DW-1:0] + DW'(1)) : work_q[DW-1:0];
  assign rem  = neg_rem_q ? (~work_q[2*DW:DW+1] + DW'(1)) : work_q[2*DW:DW+1];

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstActive) begin
      state_q <= DivFree;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DivFree: begin
        if (op_go) begin
          if (div_zero) begin
            state_d = DivByZero;
          end else if (early_out) begin
            state_d = DivEnd;
          end else begin
            state_d = DivOn;
          end
        end
      end
      DivByZero: state_d = annul_i ? DivFree : DivEnd;
      DivOn: begin
        if (annul_i) begin
          state_d = DivFree;
        end else if (cnt_q == CntDone) begin
          state_d = DivEnd;
        end
      end
      DivEnd: begin
        if (annul_i || (start_i == DivStop)) begin
          state_d = DivFree;
        end
      end
      default: state_d = DivFree;
    endcase
  end

  // Datapath next-state: operand capture, iteration and sign fix
  always_comb begin
    cnt_d      = cnt_q;
    work_d     = work_q;
    divisor_d  = divisor_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    unique case (state_q)
      DivFree: begin
        if (op_go) begin
          cnt_d      = '0;
          divisor_d  = abs2;
          neg_quot_d = signed_div_i && (opdata1_i[DW-1] ^ opdata2_i[DW-1]);
          neg_rem_d  = signed_div_i && opdata1_i[DW-1];
          if (div_zero) begin
            work_d = '0;
          end else if (early_out) begin
            work_d = {opdata1_i, 1'b0, ZeroWord};
          end else begin
            work_d = {ZeroWord, abs1, 1'b0};
          end
        end
      end
      DivByZero: work_d = '0;
      DivOn: begin
        if (annul_i) begin
          work_d = '0;
          cnt_d  = '0;
        end else if (cnt_q != CntDone) begin
          cnt_d  = cnt_q + 6'd1;
          work_d = diff[DW] ? {work_q[2*DW-1:0], 1'b0}
                            : {diff[DW-1:0], work_q[DW-1:0], 1'b1};
        end else begin
          // Final layout keeps remainder in [64:33] and quotient in [31:0].
          work_d = {rem, 1'b0, quot};
          cnt_d  = '0;
        end
      end
      DivEnd: begin
        if (state_d == DivFree) begin
          work_d = '0;
        end
      end
      default: begin
        work_d = '0;
        cnt_d  = '0;
      end
    endcase
  end

  // Output logic: the result is only ever presented while END is held by start_i
  always_comb begin
    ready_d  = DivResultNotReady;
    result_d = '0;
    if ((state_q == DivEnd) && (state_d == DivEnd)) begin
      ready_d  = DivResultReady;
      result_d = {work_q[2*DW:DW+1], work_q[DW-1:0]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstActive) begin
      cnt_q      <= '0;
      work_q     <= '0;
      divisor_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= DivResultNotReady;
    end else begin
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      divisor_q  <= divisor_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// Directed self-checking bench for div; expected latencies follow DIV_EARLY_OUT_EN.
module tb_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1, op2;
  logic        start, annul;
  logic [63:0] result;
  logic        ready;

  int total = 0;
  int bad   = 0;

  div #(.DW(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  always #5 clk = ~clk;

  // Drives a request; returns just after edge N (the edge FREE samples it).
  task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    signed_div = s;
    op1        = a;
    op2        = b;
    start      = 1'b1;
    annul      = 1'b0;
    @(posedge clk);
  endtask

  // Waits for ready; lat counts edges after N, -1 if the bound expires.
  task automatic wait_ready(output logic [63:0] res, output int lat);
    lat = -1;
    res = '0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (ready === 1'b1) begin
        lat = k;
        res = result;
        break;
      end
    end
  endtask

  task automatic release_start;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1 rst = 1'b0;
    #2;
    total++;
    if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", ready); end
    total++;
    if (result !== 64'h0) begin bad++; $display("FAIL reset_result: got %h want 0", result); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_divu_basic;
    logic [63:0] res;
    int lat;
    launch(1'b0, 32'd100, 32'd7);
    wait_ready(res, lat);
    total++;
    if (lat !== 34) begin bad++; $display("FAIL divu_latency: got %0d want 34", lat); end
    total++;
    if (res !== {32'd2, 32'd14}) begin
      bad++; $display("FAIL divu_100_7: got %h want %h", res, {32'd2, 32'd14});
    end
    release_start;
    total++;
    if (ready !== 1'b0) begin bad++; $display("FAIL divu_drop_ready: got %b want 0", ready); end
    total++;
    if (result !== 64'h0) begin bad++; $display("FAIL divu_drop_result: got %h want 0", result); end
  endtask

  task automatic test_signed;
    logic [63:0] res;
    int lat;
    launch(1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_ready(res, lat);
    total++;
    if (lat !== 34) begin bad++; $display("FAIL div_m7_2_latency: got %0d want 34", lat); end
    total++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      bad++; $display("FAIL div_m7_2: got %h want FFFFFFFFFFFFFFFD", res);
    end
    release_start;
    launch(1'b1, 32'd7, 32'hFFFF_FFFE);
    wait_ready(res, lat);
    total++;
    if (lat !== 34) begin bad++; $display("FAIL div_7_m2_latency: got %0d want 34", lat); end
    total++;
    if (res !== 64'h0000_0001_FFFF_FFFD) begin
      bad++; $display("FAIL div_7_m2: got %h want 00000001FFFFFFFD", res);
    end
    release_start;
    launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_ready(res, lat);
    total++;
    if (lat !== 34) begin bad++; $display("FAIL div_ovf_latency: got %0d want 34", lat); end
    total++;
    if (res !== 64'h0000_0000_8000_0000) begin
      bad++; $display("FAIL div_ovf: got %h want 0000000080000000", res);
    end
    release_start;
  endtask

  task automatic test_by_zero;
    logic [63:0] res;
    int lat;
    launch(1'b1, 32'd5, 32'd0);
    wait_ready(res, lat);
    total++;
    if (lat !== 2) begin bad++; $display("FAIL byzero_latency: got %0d want 2", lat); end
    total++;
    if (res !== 64'h0) begin bad++; $display("FAIL byzero_result: got %h want 0", res); end
    release_start;
    total++;
    if (ready !== 1'b0) begin bad++; $display("FAIL byzero_drop_ready: got %b want 0", ready); end
  endtask

  task automatic test_annul;
    logic [63:0] res;
    int lat;
    int seen;
    launch(1'b0, 32'hFFFF_FFFF, 32'd3);
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul = 1'b1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    annul = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (ready !== 1'b0) seen++;
    end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL annul_no_ready: got %0d ready cycles want 0", seen); end
    launch(1'b0, 32'd9, 32'd3);
    wait_ready(res, lat);
    total++;
    if (lat !== 34) begin bad++; $display("FAIL annul_next_latency: got %0d want 34", lat); end
    total++;
    if (res !== {32'd0, 32'd3}) begin
      bad++; $display("FAIL annul_next_9_3: got %h want %h", res, {32'd0, 32'd3});
    end
    release_start;
  endtask

  task automatic test_hold_end;
    logic [63:0] res;
    int lat;
    launch(1'b0, 32'd1000, 32'd10);
    wait_ready(res, lat);
    total++;
    if (res !== {32'd0, 32'd100}) begin
      bad++; $display("FAIL hold_first: got %h want %h", res, {32'd0, 32'd100});
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      total++;
      if (ready !== 1'b1 || result !== {32'd0, 32'd100}) begin
        bad++; $display("FAIL hold_stable: cycle %0d got ready=%b %h want 1 %h", k, ready,
                        result, {32'd0, 32'd100});
      end
    end
    release_start;
    total++;
    if (ready !== 1'b0 || result !== 64'h0) begin
      bad++; $display("FAIL hold_drop: got ready=%b %h want 0 0", ready, result);
    end
  endtask

  task automatic test_async_reset;
    logic [63:0] res;
    int lat;
    launch(1'b0, 32'd100, 32'd7);
    repeat (20) @(posedge clk);
    #3;
    rst   = 1'b0;
    start = 1'b0;
    #1;
    total++;
    if (ready !== 1'b0 || result !== 64'h0) begin
      bad++; $display("FAIL rst_midop: got ready=%b %h want 0 0", ready, result);
    end
    @(negedge clk);
    rst = 1'b1;
    launch(1'b0, 32'd100, 32'd7);
    wait_ready(res, lat);
    total++;
    if (lat !== 34 || res !== {32'd2, 32'd14}) begin
      bad++; $display("FAIL rst_clean_op: got lat=%0d %h want 34 %h", lat, res, {32'd2, 32'd14});
    end
    // Reset while the result is being presented must clear it before the next edge.
    #2 rst = 1'b0;
    start = 1'b0;
    #1;
    total++;
    if (ready !== 1'b0 || result !== 64'h0) begin
      bad++; $display("FAIL rst_in_end: got ready=%b %h want 0 0", ready, result);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_early_out;
    logic [63:0] res;
    int lat;
    int want_lat;
`ifdef DIV_EARLY_OUT_EN
    want_lat = 1;
`else
    want_lat = 34;
`endif
    launch(1'b0, 32'd3, 32'd10);
    wait_ready(res, lat);
    total++;
    if (lat !== want_lat) begin
      bad++; $display("FAIL early_latency: got %0d want %0d", lat, want_lat);
    end
    total++;
    if (res !== {32'd3, 32'd0}) begin
      bad++; $display("FAIL early_3_10: got %h want %h", res, {32'd3, 32'd0});
    end
    release_start;
  endtask

  initial begin
    rst        = 1'b1;
    signed_div = 1'b0;
    op1        = '0;
    op2        = '0;
    start      = 1'b0;
    annul      = 1'b0;
    test_reset;
    test_divu_basic;
    test_signed;
    test_by_zero;
    test_annul;
    test_hold_end;
    test_async_reset;
    test_early_out;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
